// File: rtl/pc_fpga_pkg.sv
// Shared constants and types for the pc_sn_7_3 parallel-counter FPGA build.
package pc_fpga_pkg;

  localparam int PC_IN_W                 = 7;
  localparam int PC_OUT_W                = 3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 100000;
  localparam int CLK_HZ                  = 100_000_000;

  typedef logic [PC_IN_W-1:0] sw_vec_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter and stable flop.
// Defining DEBOUNCE_BYPASS_EN removes the counter and follows sync2 directly.
module sw_debounce_bit
  import pc_fpga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_stable,
  output logic update
);

  logic sync1_q, sync2_q;
  logic stable_q, stable_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= sw_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
    end
  end

`ifdef DEBOUNCE_BYPASS_EN
  always_comb begin
    stable_d = sync2_q;
    update   = (sync2_q != stable_q);
  end
`else
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle of agreement restarts the count; the counter stops at CNT_MAX.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    update   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      update   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign sw_stable = stable_q;

endmodule

// File: rtl/sw_debounce_sync.sv
// Synchronises and debounces WIDTH slide switches for the parallel counter.
// Optional macro DEBOUNCE_BYPASS_EN (in sw_debounce_bit) skips debouncing.
module sw_debounce_sync
  import pc_fpga_pkg::*;
#(
  parameter int WIDTH           = PC_IN_W,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed
);

  logic [WIDTH-1:0] update_vec;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .sw_raw   (sw_raw[i]),
      .sw_stable(sw_stable[i]),
      .update   (update_vec[i])
    );
  end

  // Registered alongside the stable flops so the pulse lines up with the new value.
  always_comb begin
    changed_d = |update_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) changed_q <= 1'b0;
    else     changed_q <= changed_d;
  end

  assign sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed self-checking bench for sw_debounce_sync with DEBOUNCE_CYCLES = 4.
module tb_sw_debounce_sync;

  logic       clk;
  logic       rst;
  logic [6:0] sw_raw;
  logic [6:0] sw_stable;
  logic       sw_changed;

  int checks = 0;
  int errors = 0;

  sw_debounce_sync #(
    .WIDTH(7),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_changed(sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the next rising edge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    sw_raw = 7'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] exp_s;
    logic       exp_c;
    rst    = 1'b1;
    sw_raw = 7'h7F;
    repeat (3) @(negedge clk);
    checks++;
    if (sw_stable !== 7'h00) begin
      errors++;
      $display("[TB] FAIL reset_stable: got %h expected %h", sw_stable, 7'h00);
    end
    checks++;
    if (sw_changed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_changed: got %b expected %b", sw_changed, 1'b0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_s = (k >= 6) ? 7'h7F : 7'h00;
      exp_c = (k == 6);
      checks++;
      if (sw_stable !== exp_s || sw_changed !== exp_c) begin
        errors++;
        $display("[TB] FAIL reset_release edge %0d: got %h/%b expected %h/%b",
                 k, sw_stable, sw_changed, exp_s, exp_c);
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [6:0] exp_s;
    logic       exp_c;
    do_reset();
    sw_raw = 7'h01;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_s = (k >= 6) ? 7'h01 : 7'h00;
      exp_c = (k == 6);
      checks++;
      if (sw_stable !== exp_s || sw_changed !== exp_c) begin
        errors++;
        $display("[TB] FAIL clean_rise edge %0d: got %h/%b expected %h/%b",
                 k, sw_stable, sw_changed, exp_s, exp_c);
      end
    end
  endtask

  task automatic test_bounce();
    logic [6:0] pattern [4];
    pattern[0] = 7'h08;
    pattern[1] = 7'h00;
    pattern[2] = 7'h08;
    pattern[3] = 7'h00;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      sw_raw = (k <= 4) ? pattern[k-1] : 7'h00;
      @(negedge clk);
      checks++;
      if (sw_stable !== 7'h00 || sw_changed !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bounce edge %0d: got %h/%b expected %h/%b",
                 k, sw_stable, sw_changed, 7'h00, 1'b0);
      end
    end
  endtask

  // Three high cycles, one low, then steady high: sync2 rises for good at
  // edge 6, so the update lands on edge 10.
  task automatic test_restart();
    logic [6:0] exp_s;
    logic       exp_c;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      sw_raw = (k == 4) ? 7'h00 : 7'h04;
      @(negedge clk);
      exp_s = (k >= 10) ? 7'h04 : 7'h00;
      exp_c = (k == 10);
      checks++;
      if (sw_stable !== exp_s || sw_changed !== exp_c) begin
        errors++;
        $display("[TB] FAIL restart edge %0d: got %h/%b expected %h/%b",
                 k, sw_stable, sw_changed, exp_s, exp_c);
      end
    end
  endtask

  task automatic test_multi_bit();
    logic [6:0] exp_s;
    logic       exp_c;
    do_reset();
    sw_raw = 7'h55;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_s = (k >= 6) ? 7'h55 : 7'h00;
      exp_c = (k == 6);
      checks++;
      if (sw_stable !== exp_s || sw_changed !== exp_c) begin
        errors++;
        $display("[TB] FAIL multi_rise edge %0d: got %h/%b expected %h/%b",
                 k, sw_stable, sw_changed, exp_s, exp_c);
      end
    end
    sw_raw = 7'h54;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_s = (k >= 6) ? 7'h54 : 7'h55;
      exp_c = (k == 6);
      checks++;
      if (sw_stable !== exp_s || sw_changed !== exp_c) begin
        errors++;
        $display("[TB] FAIL multi_fall edge %0d: got %h/%b expected %h/%b",
                 k, sw_stable, sw_changed, exp_s, exp_c);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_s;
    logic       exp_c;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      sw_raw = (k == 1) ? 7'h02 : 7'h12;
      @(negedge clk);
      exp_s = (k >= 7) ? 7'h12 : ((k == 6) ? 7'h02 : 7'h00);
      exp_c = (k == 6) || (k == 7);
      checks++;
      if (sw_stable !== exp_s || sw_changed !== exp_c) begin
        errors++;
        $display("[TB] FAIL back_to_back edge %0d: got %h/%b expected %h/%b",
                 k, sw_stable, sw_changed, exp_s, exp_c);
      end
    end
  endtask

  // Bit 0 already stable, bit 5 at count 2 when reset hits asynchronously.
  task automatic test_reset_midcount();
    logic [6:0] exp_s;
    logic       exp_c;
    do_reset();
    sw_raw = 7'h01;
    repeat (7) @(negedge clk);
    checks++;
    if (sw_stable !== 7'h01) begin
      errors++;
      $display("[TB] FAIL midcount_pre: got %h expected %h", sw_stable, 7'h01);
    end
    sw_raw = 7'h21;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (sw_stable !== 7'h00 || sw_changed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midcount_async_clear: got %h/%b expected %h/%b",
               sw_stable, sw_changed, 7'h00, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_s = (k >= 6) ? 7'h21 : 7'h00;
      exp_c = (k == 6);
      checks++;
      if (sw_stable !== exp_s || sw_changed !== exp_c) begin
        errors++;
        $display("[TB] FAIL midcount_reacquire edge %0d: got %h/%b expected %h/%b",
                 k, sw_stable, sw_changed, exp_s, exp_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_bounce();
    test_restart();
    test_multi_bit();
    test_back_to_back();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
